data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Single-port word memory with a load/store request/response handshake, RISC-V sized accesses.
// Define MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them down.
module data_mem_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [31:0] rdata_q, rdata_nx;
  logic        err_q, err_nx;
  logic [31:0] mem [DEPTH];

  logic [1:0]  sz;
  logic        uns, unsupported, misaligned, in_range, acc_err;
  logic [1:0]  lo;
  logic [29:0] widx;
  logic [AW-1:0] idx;
  logic [31:0] rword, load_data, wdata_rep;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [3:0]  be;
  logic        accept, do_write;

  assign sz          = req_size[1:0];
  assign uns         = req_size[2];
  assign unsupported = (sz == 2'b11) || (uns && sz == 2'b10);
  assign misaligned  = (sz == 2'b01 && req_addr[0]) || (sz == 2'b10 && req_addr[1:0] != 2'b00);
  assign widx        = req_addr[31:2];
  assign in_range    = widx < 30'(DEPTH);
  assign idx         = widx[AW-1:0];

`ifdef MISALIGN_TRAP_EN
  assign lo      = req_addr[1:0];
  assign acc_err = !in_range || unsupported || misaligned;
`else
  // Misaligned halves/words are aligned down and treated as legal.
  always_comb begin
    lo = req_addr[1:0];
    if (sz == 2'b01 && misaligned)      lo = {req_addr[1], 1'b0};
    else if (sz == 2'b10 && misaligned) lo = 2'b00;
  end
  assign acc_err = !in_range || unsupported;
`endif

  assign rword = mem[idx];
  assign rbyte = rword[{lo, 3'b000} +: 8];
  assign rhalf = lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    wdata_rep = req_wdata;
    be        = 4'b1111;
    case (sz)
      2'b00: begin
        load_data = uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        wdata_rep = {4{req_wdata[7:0]}};
        be        = 4'b0001 << lo;
      end
      2'b01: begin
        load_data = uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        wdata_rep = {2{req_wdata[15:0]}};
        be        = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign accept   = (state == IDLE) && req_valid;
  assign do_write = accept && req_we && !acc_err;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: if (req_valid) begin
        err_nx   = acc_err;
        rdata_nx = (req_we || acc_err) ? '0 : load_data;
        cnt_nx   = '0;
        state_nx = (req_we || READ_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        // WAIT spans READ_LAT-1 cycles: cnt runs 0 .. READ_LAT-2.
        if (cnt == 2'(READ_LAT - 2)) state_nx = RESP;
        else                         cnt_nx   = cnt + 2'd1;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      for (int unsigned b = 0; b < 4; b++)
        if (do_write && be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (READ_LAT 1, 3, 2) checked with immediate assertions.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // READ_LAT=1 instance
  logic rst = 1'b1;
  logic v1 = 0, we1 = 0, rr1 = 0;
  logic [2:0] sz1 = '0;
  logic [31:0] a1 = '0, wd1 = '0;
  logic rdy1, rv1, re1;
  logic [31:0] rd1;

  data_mem_ctrl #(.DEPTH(64), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_size(sz1), .req_addr(a1), .req_wdata(wd1), .rsp_valid(rv1),
    .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(re1));

  // READ_LAT=3 instance
  logic v3 = 0, we3 = 0, rr3 = 0;
  logic [2:0] sz3 = 3'b010;
  logic [31:0] a3 = '0, wd3 = '0;
  logic rdy3, rv3, re3;
  logic [31:0] rd3;

  data_mem_ctrl #(.DEPTH(64), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_size(sz3), .req_addr(a3), .req_wdata(wd3), .rsp_valid(rv3),
    .rsp_ready(rr3), .rsp_rdata(rd3), .rsp_err(re3));

  // READ_LAT=2 instance with its own reset
  logic rst2 = 1'b1;
  logic v2 = 0, we2 = 0, rr2 = 0;
  logic [2:0] sz2 = 3'b010;
  logic [31:0] a2 = '0, wd2 = '0;
  logic rdy2, rv2, re2;
  logic [31:0] rd2;

  data_mem_ctrl #(.DEPTH(64), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
    .req_size(sz2), .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2),
    .rsp_ready(rr2), .rsp_rdata(rd2), .rsp_err(re2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut1; READ_LAT=1 so every response lands one cycle after acceptance.
  task automatic txn1(input string tag, input logic we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    chk({tag, " req_ready"}, {31'b0, rdy1}, 32'd1);
    v1 = 1; we1 = we; sz1 = sz; a1 = a; wd1 = wd;
    @(posedge clk);
    @(negedge clk);
    v1 = 0;
    chk({tag, " rsp_valid"}, {31'b0, rv1}, 32'd1);
    chk({tag, " rdata"}, rd1, exp_d);
    chk({tag, " err"}, {31'b0, re1}, {31'b0, exp_e});
    rr1 = 1;
    @(posedge clk);
    @(negedge clk);
    rr1 = 0;
    chk({tag, " rsp_valid after ack"}, {31'b0, rv1}, 32'd0);
  endtask

  logic [31:0] held;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", {31'b0, rv1}, 32'd0);
    chk("reset rdata", rd1, 32'd0);
    chk("reset err", {31'b0, re1}, 32'd0);
    rst = 0; rst2 = 0;
    @(negedge clk);
    chk("post-reset req_ready1", {31'b0, rdy1}, 32'd1);
    chk("post-reset req_ready3", {31'b0, rdy3}, 32'd1);
    chk("post-reset req_ready2", {31'b0, rdy2}, 32'd1);

    // Word store/load and sub-word lanes
    txn1("sw 0x10", 1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 0);
    txn1("lw 0x10", 0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 0);
    txn1("sb 0x11", 1, 3'b000, 32'h11, 32'hFFFF_FF5A, 32'h0, 0);
    txn1("lb 0x11", 0, 3'b000, 32'h11, 32'h0, 32'h0000_005A, 0);
    txn1("lbu 0x13", 0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 0);
    txn1("lb 0x13", 0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 0);
    txn1("lh 0x12", 0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 0);
    txn1("lhu 0x12", 0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 0);
    txn1("lw 0x10 merged", 0, 3'b010, 32'h10, 32'h0, 32'h8000_5AF0, 0);

    // Range and size errors
    txn1("sw 0x100 oor", 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 1);
    txn1("lw 0x0 after oor", 0, 3'b010, 32'h0, 32'h0, 32'h0, 0);
    txn1("sw 0xFC last", 1, 3'b010, 32'hFC, 32'hCAFE_F00D, 32'h0, 0);
    txn1("lw 0xFC last", 0, 3'b010, 32'hFC, 32'h0, 32'hCAFE_F00D, 0);
    txn1("lw 0x100 oor", 0, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    txn1("size 011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    txn1("size 110", 0, 3'b110, 32'h10, 32'h0, 32'h0, 1);

    // Misaligned half store
`ifdef MISALIGN_TRAP_EN
    txn1("sh 0x21 misaligned", 1, 3'b001, 32'h21, 32'hABCD_1234, 32'h0, 1);
    txn1("lhu 0x20", 0, 3'b101, 32'h20, 32'h0, 32'h0, 0);
`else
    txn1("sh 0x21 misaligned", 1, 3'b001, 32'h21, 32'hABCD_1234, 32'h0, 0);
    txn1("lhu 0x20", 0, 3'b101, 32'h20, 32'h0, 32'h0000_1234, 0);
`endif

    // READ_LAT=3: store still answers after one cycle
    @(negedge clk);
    v3 = 1; we3 = 1; a3 = 32'h8; wd3 = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    v3 = 0;
    chk("lat3 store rsp_valid", {31'b0, rv3}, 32'd1);
    rr3 = 1;
    @(posedge clk);
    @(negedge clk);
    rr3 = 0;
    // Load held valid throughout, response stalled for 5 cycles
    v3 = 1; we3 = 0; a3 = 32'h8;
    @(posedge clk);
    @(negedge clk);
    chk("lat3 +1 rsp_valid", {31'b0, rv3}, 32'd0);
    chk("lat3 +1 req_ready", {31'b0, rdy3}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat3 +2 rsp_valid", {31'b0, rv3}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat3 +3 rsp_valid", {31'b0, rv3}, 32'd1);
    chk("lat3 rdata", rd3, 32'h1122_3344);
    held = rd3;
    a3 = 32'h0; we3 = 1; wd3 = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("lat3 stall rsp_valid", {31'b0, rv3}, 32'd1);
      chk("lat3 stall rdata", rd3, held);
      chk("lat3 stall req_ready", {31'b0, rdy3}, 32'd0);
    end
    rr3 = 1;
    @(posedge clk);
    @(negedge clk);
    rr3 = 0; v3 = 0;
    chk("lat3 post-ack req_ready", {31'b0, rdy3}, 32'd1);
    chk("lat3 post-ack rsp_valid", {31'b0, rv3}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat3 no queued rsp", {31'b0, rv3}, 32'd0);
    // The stalled store to 0x0 must not have been taken
    v3 = 1; we3 = 0; a3 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    v3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat3 ignored store rsp_valid", {31'b0, rv3}, 32'd1);
    chk("lat3 ignored store rdata", rd3, 32'h0);
    rr3 = 1;
    @(posedge clk);
    @(negedge clk);
    rr3 = 0;

    // READ_LAT=2: reset during WAIT aborts the load and clears memory
    v2 = 1; we2 = 1; a2 = 32'h4; wd2 = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    v2 = 0;
    chk("lat2 store rsp_valid", {31'b0, rv2}, 32'd1);
    rr2 = 1;
    @(posedge clk);
    @(negedge clk);
    rr2 = 0;
    v2 = 1; we2 = 0; a2 = 32'h4;
    @(posedge clk);
    @(negedge clk);
    v2 = 0;
    chk("lat2 wait rsp_valid", {31'b0, rv2}, 32'd0);
    rst2 = 1;
    @(posedge clk);
    @(negedge clk);
    rst2 = 0;
    chk("lat2 abort rsp_valid", {31'b0, rv2}, 32'd0);
    chk("lat2 req_ready after rst", {31'b0, rdy2}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("lat2 abort still idle", {31'b0, rv2}, 32'd0);
    v2 = 1; we2 = 0; a2 = 32'h4;
    @(posedge clk);
    @(negedge clk);
    v2 = 0;
    @(posedge clk);
    @(negedge clk);
    chk("lat2 reload rsp_valid", {31'b0, rv2}, 32'd1);
    chk("lat2 reload rdata cleared", rd2, 32'h0);
    rr2 = 1;
    @(posedge clk);
    @(negedge clk);
    rr2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
